// File: rtl/isp_ccm_cfg_loader.sv
// Double-buffered colour-correction matrix loader: host fills a shadow bank, commit arms it,
// next frame boundary copies it to the active bank. Optional readback: ISP_CCM_CFG_READBACK_EN.
module isp_ccm_cfg_loader #(
  parameter int unsigned COEF_WIDTH = 12,
  parameter int unsigned NUM_COEF   = 9
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [3:0]                     wr_addr_i,
  input  logic [COEF_WIDTH-1:0]          wr_data_i,
  input  logic                           enable_req_i,
  input  logic                           commit_i,
  input  logic                           frame_start_i,
  input  logic                           err_clr_i,
`ifdef ISP_CCM_CFG_READBACK_EN
  input  logic                           rd_sel_i,
  input  logic [3:0]                     rd_addr_i,
  output logic [COEF_WIDTH-1:0]          rd_data_o,
`endif
  output logic [NUM_COEF*COEF_WIDTH-1:0] cfg_matrix_o,
  output logic                           cfg_enable_o,
  output logic                           busy_o,
  output logic                           update_o,
  output logic                           err_addr_o,
  output logic                           err_seq_o
);

  typedef enum logic [1:0] {StIdle, StArmed, StUpdate} state_e;

  localparam logic [4:0] NumCoefW = 5'(NUM_COEF);

  state_e                state_q, state_d;
  logic [COEF_WIDTH-1:0] shadow_q [NUM_COEF];
  logic [COEF_WIDTH-1:0] active_q [NUM_COEF];
  logic                  sh_en_q, act_en_q;
  logic                  err_addr_q, err_seq_q;

  logic wr_fire, addr_ok, commit_idle, commit_busy, apply;

  assign wr_fire     = wr_valid_i && (state_q == StIdle);
  assign addr_ok     = {1'b0, wr_addr_i} < NumCoefW;
  assign commit_idle = commit_i && (state_q == StIdle);
  assign commit_busy = commit_i && (state_q != StIdle);
  assign apply       = frame_start_i && (state_q == StArmed);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (commit_i) state_d = StArmed;
      StArmed:  if (frame_start_i) state_d = StUpdate;
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      sh_en_q    <= 1'b0;
      act_en_q   <= 1'b0;
      err_addr_q <= 1'b0;
      err_seq_q  <= 1'b0;
      for (int unsigned k = 0; k < NUM_COEF; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (commit_idle) sh_en_q <= enable_req_i;
      if (apply) act_en_q <= sh_en_q;
      for (int unsigned k = 0; k < NUM_COEF; k++) begin
        if (wr_fire && addr_ok && (wr_addr_i == 4'(k))) shadow_q[k] <= wr_data_i;
        if (apply) active_q[k] <= shadow_q[k];
      end
      // A coincident set event takes priority over the clear.
      if (wr_fire && !addr_ok) err_addr_q <= 1'b1;
      else if (err_clr_i)      err_addr_q <= 1'b0;
      if (commit_busy)         err_seq_q  <= 1'b1;
      else if (err_clr_i)      err_seq_q  <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_COEF; g++) begin : g_pack
    assign cfg_matrix_o[g*COEF_WIDTH +: COEF_WIDTH] = active_q[g];
  end

  assign cfg_enable_o = act_en_q;
  assign wr_ready_o   = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign update_o     = (state_q == StUpdate);
  assign err_addr_o   = err_addr_q;
  assign err_seq_o    = err_seq_q;

`ifdef ISP_CCM_CFG_READBACK_EN
  logic [COEF_WIDTH-1:0] rd_mux, rd_data_q;

  // Addresses past the last coefficient fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < NUM_COEF; k++) begin
      if (rd_addr_i == 4'(k)) rd_mux = rd_sel_i ? active_q[k] : shadow_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_mux;
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_isp_ccm_cfg_loader.sv
// Directed self-checking bench for isp_ccm_cfg_loader (default build, readback disabled).
module tb_isp_ccm_cfg_loader;

  localparam int W = 12;
  localparam int N = 9;

  logic           clk_i = 1'b0;
  logic           rst_i, wr_valid_i, enable_req_i, commit_i, frame_start_i, err_clr_i;
  logic [3:0]     wr_addr_i;
  logic [W-1:0]   wr_data_i;
  logic           wr_ready_o, cfg_enable_o, busy_o, update_o, err_addr_o, err_seq_o;
  logic [N*W-1:0] cfg_matrix_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_upd;

  isp_ccm_cfg_loader #(.COEF_WIDTH(W), .NUM_COEF(N)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_valid_i   (wr_valid_i),
    .wr_ready_o   (wr_ready_o),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .enable_req_i (enable_req_i),
    .commit_i     (commit_i),
    .frame_start_i(frame_start_i),
    .err_clr_i    (err_clr_i),
    .cfg_matrix_o (cfg_matrix_o),
    .cfg_enable_o (cfg_enable_o),
    .busy_o       (busy_o),
    .update_o     (update_o),
    .err_addr_o   (err_addr_o),
    .err_seq_o    (err_seq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] coef(input int k);
    return cfg_matrix_o[k*W +: W];
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [W-1:0] d);
    wr_valid_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    cyc();
    wr_valid_i = 1'b0;
  endtask

  task automatic check_matrix(input string tag, input logic [W-1:0] base, input logic zero);
    for (int k = 0; k < N; k++)
      check($sformatf("%s[%0d]", tag, k), 32'(coef(k)), zero ? 32'h0 : 32'(base + W'(k)));
  endtask

  initial begin
    rst_i = 1'b1; wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    enable_req_i = 1'b0; commit_i = 1'b0; frame_start_i = 1'b0; err_clr_i = 1'b0;
    cyc(); cyc();
    rst_i = 1'b0;
    cyc();

    // Reset state
    check("rst_ready", wr_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_update", update_o, 0);
    check("rst_enable", cfg_enable_o, 0);
    check("rst_err_addr", err_addr_o, 0);
    check("rst_err_seq", err_seq_o, 0);
    check_matrix("rst_coef", 0, 1'b1);

    // Full load, commit, apply five cycles later
    for (int k = 0; k < N; k++) write(4'(k), W'(12'h100 + k));
    check_matrix("shadow_no_leak", 0, 1'b1);
    enable_req_i = 1'b1; commit_i = 1'b1;
    cyc();
    commit_i = 1'b0; enable_req_i = 1'b0;
    check("armed_busy", busy_o, 1);
    check("armed_ready", wr_ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      check("armed_hold_coef0", 32'(coef(0)), 0);
      check("armed_no_update", update_o, 0);
      cyc();
    end
    frame_start_i = 1'b1;
    cyc();
    frame_start_i = 1'b0;
    check("apply_update", update_o, 1);
    check("apply_enable", cfg_enable_o, 1);
    check_matrix("apply_coef", 12'h100, 1'b0);
    cyc();
    check("post_update", update_o, 0);
    check("post_busy", busy_o, 0);
    check("post_ready", wr_ready_o, 1);

    // Bad address, clear, set-wins-over-clear
    write(4'd9, 12'hABC);
    check("bad_addr_err", err_addr_o, 1);
    check("bad_addr_coef8", 32'(coef(8)), 32'h108);
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;
    check("err_addr_clr", err_addr_o, 0);
    err_clr_i = 1'b1;
    write(4'd15, 12'h123);
    err_clr_i = 1'b0;
    check("err_set_wins", err_addr_o, 1);
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;

    // Second commit while armed is ignored and flagged
    enable_req_i = 1'b0; commit_i = 1'b1;
    cyc();
    enable_req_i = 1'b1;
    cyc();
    commit_i = 1'b0; enable_req_i = 1'b0;
    check("seq_err", err_seq_o, 1);
    check("seq_ready", wr_ready_o, 0);
    n_upd = 0;
    frame_start_i = 1'b1;
    cyc();
    frame_start_i = 1'b0;
    check("seq_ready_upd", wr_ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      if (update_o) n_upd++;
      cyc();
    end
    check("seq_one_pulse", n_upd, 1);
    check("seq_enable_ignored", cfg_enable_o, 0);
    check("seq_ready_back", wr_ready_o, 1);
    check_matrix("seq_shadow_kept", 12'h100, 1'b0);

    // Commit coincident with frame_start does not apply
    enable_req_i = 1'b1; commit_i = 1'b1; frame_start_i = 1'b1;
    cyc();
    enable_req_i = 1'b0; commit_i = 1'b0; frame_start_i = 1'b0;
    check("coinc_no_update", update_o, 0);
    check("coinc_enable_old", cfg_enable_o, 0);
    check("coinc_busy", busy_o, 1);
    cyc();
    check("coinc_still_armed", update_o, 0);
    frame_start_i = 1'b1;
    cyc();
    frame_start_i = 1'b0;
    check("coinc_next_update", update_o, 1);
    check("coinc_next_enable", cfg_enable_o, 1);
    cyc();

    // Write and commit in the same cycle
    wr_valid_i = 1'b1; wr_addr_i = 4'd4; wr_data_i = 12'hFDA;
    enable_req_i = 1'b1; commit_i = 1'b1;
    cyc();
    wr_valid_i = 1'b0; commit_i = 1'b0; enable_req_i = 1'b0;
    check("wc_busy", busy_o, 1);
    check("wc_coef4_hold", 32'(coef(4)), 32'h104);
    frame_start_i = 1'b1;
    cyc();
    frame_start_i = 1'b0;
    check("wc_coef4", 32'(coef(4)), 32'hFDA);
    check("wc_coef3", 32'(coef(3)), 32'h103);
    check("wc_coef5", 32'(coef(5)), 32'h105);
    cyc();

    // Reset while armed drops the pending set
    write(4'd0, 12'h055);
    enable_req_i = 1'b1; commit_i = 1'b1;
    cyc();
    commit_i = 1'b0; enable_req_i = 1'b0;
    check("rarm_busy", busy_o, 1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    check_matrix("rarm_coef", 0, 1'b1);
    check("rarm_enable", cfg_enable_o, 0);
    check("rarm_busy0", busy_o, 0);
    check("rarm_update", update_o, 0);
    check("rarm_err_seq", err_seq_o, 0);
    check("rarm_err_addr", err_addr_o, 0);
    check("rarm_ready", wr_ready_o, 1);
    n_upd = 0;
    frame_start_i = 1'b1;
    cyc();
    frame_start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (update_o) n_upd++;
      cyc();
    end
    check("rarm_no_update", n_upd, 0);
    check("rarm_coef0", 32'(coef(0)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/isp_ccm_cfg_loader.md
ISP_CCM_CFG_LOADER -- requirements
Module: isp_ccm_cfg_loader

Interface
REQ-001 Parameter COEF_WIDTH, default 12, width of one colour-correction coefficient (signed two's complement).
REQ-002 Parameter NUM_COEF, default 9, number of matrix coefficients, row-major (Rr Rg Rb Gr Gg Gb Br Bg Bb).
REQ-003 clk_i  input  1  single block clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 wr_valid_i  input  1  coefficient write request.
REQ-006 wr_ready_o  output  1  write can be accepted this cycle.
REQ-007 wr_addr_i  input  4  coefficient index 0..NUM_COEF-1.
REQ-008 wr_data_i  input  COEF_WIDTH  coefficient value.
REQ-009 enable_req_i  input  1  requested matrix-enable, sampled on commit.
REQ-010 commit_i  input  1  single-cycle pulse: arm shadow set for next frame.
REQ-011 frame_start_i  input  1  single-cycle frame boundary pulse from the ISP timing generator.
REQ-012 err_clr_i  input  1  clears sticky error flags.
REQ-013 cfg_matrix_o  output  NUM_COEF x COEF_WIDTH  active matrix, feeds the CCM stage's cfg_matrix_i.
REQ-014 cfg_enable_o  output  1  active enable, feeds the CCM stage's cfg_enable_i.
REQ-015 busy_o  output  1  high in ARMED or UPDATE.
REQ-016 update_o  output  1  one-cycle pulse when the active set has just changed.
REQ-017 err_addr_o / err_seq_o  output  1 each  sticky: bad write address / commit while busy.

Function
REQ-018 Two banks: shadow (written by host) and active (drives outputs); active changes only at a frame boundary.
REQ-019 FSM states IDLE, ARMED, UPDATE; wr_ready_o = 1 only in IDLE.
REQ-020 Write accepted when wr_valid_i && wr_ready_o; shadow[wr_addr_i] <= wr_data_i at that edge.
REQ-021 Accepted write with wr_addr_i >= NUM_COEF: data dropped, err_addr_o set; no shadow change.
REQ-022 IDLE + commit_i: shadow enable <= enable_req_i, next state ARMED.
REQ-023 IDLE with write and commit in same cycle: write lands in shadow and is included in the armed set.
REQ-024 ARMED + frame_start_i: active matrix and cfg_enable_o <= shadow at that edge, next state UPDATE.
REQ-025 UPDATE: update_o = 1 for exactly this cycle; next state IDLE unconditionally.
REQ-026 commit_i in ARMED or UPDATE: ignored, err_seq_o set.
REQ-027 frame_start_i in IDLE or UPDATE: no effect.
REQ-028 Commit-to-active latency: active bank updates on the first frame_start_i edge strictly after the commit edge (frame_start coincident with commit does not apply it).
REQ-029 err_clr_i clears both flags; simultaneous set event wins over clear.
REQ-030 Shadow writes never alter cfg_matrix_o; outputs are registered, no combinational path from inputs.

Reset
REQ-031 On rst_i: state IDLE, shadow and active coefficients 0, shadow enable 0, cfg_enable_o 0, busy_o 0, update_o 0, both error flags 0, wr_ready_o 1 the cycle after reset deasserts.
REQ-032 Reset asserted in ARMED discards the pending commit; active bank returns to zero.

Configuration
REQ-033 Macro ISP_CCM_CFG_READBACK_EN: when defined, adds rd_sel_i (1: 0 shadow / 1 active), rd_addr_i (4), rd_data_o (COEF_WIDTH); rd_data_o registered, 1-cycle latency, 0 for addr >= NUM_COEF, reset value 0.
REQ-034 Without ISP_CCM_CFG_READBACK_EN: those ports and logic are absent; all other behaviour identical.

Verification
REQ-035 Write addr 0..8 with 0x100..0x108, commit with enable_req_i=1, frame_start 5 cycles later -> cfg_matrix_o unchanged until that edge, then 0x100..0x108, cfg_enable_o=1, update_o one cycle, busy_o low next.
REQ-036 Write addr 9 data 0xABC -> err_addr_o=1, shadow unchanged; err_clr_i -> err_addr_o=0.
REQ-037 Commit then second commit while ARMED -> err_seq_o=1, wr_ready_o=0 until UPDATE->IDLE, single update_o pulse.
REQ-038 commit_i and frame_start_i same cycle in IDLE -> no update; next frame_start applies set.
REQ-039 Write 0xFDA to addr 4 with commit same cycle, frame_start -> cfg_matrix_o[4]=0xFDA.
REQ-040 rst_i asserted in ARMED -> all outputs zero next cycle, later frame_start produces no update_o.
